// File: rtl/dcache_wb_pkg.sv
// Shared types and widths for the direct-mapped write-back data cache.
// Word address layout is {tag, index, offset}; a memory line address is {tag, index}.
package dcache_wb_pkg;

   localparam int ADDR_W         = 30;
   localparam int INDEX_W        = 3;
   localparam int NUM_LINES      = 2 ** INDEX_W;
   localparam int OFFSET_W       = 2;
   localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINE_ADDR_W    = ADDR_W - OFFSET_W;
   localparam int WORD_W         = 32;
   localparam int WORDS_PER_LINE = 2 ** OFFSET_W;
   localparam int LINE_W         = WORD_W * WORDS_PER_LINE;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   typedef logic [TAG_W-1:0]    tag_t;
   typedef logic [INDEX_W-1:0]  index_t;
   typedef logic [OFFSET_W-1:0] offset_t;
   typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

   function automatic logic [LINE_ADDR_W-1:0] line_addr(input tag_t tag, input index_t index);
      return {tag, index};
   endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// Core-side request port and memory-side line port of the data cache.
// The cache uses the slave view; the core/memory environment uses the master view.
interface dcache_wb_if;
   import dcache_wb_pkg::*;

   logic                   proc_read;
   logic                   proc_write;
   logic [ADDR_W-1:0]      proc_addr;
   logic [WORD_W-1:0]      proc_wdata;
   logic [WORD_W-1:0]      proc_rdata;
   logic                   proc_stall;

   logic                   mem_read;
   logic                   mem_write;
   logic [LINE_ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0]      mem_wdata;
   logic [LINE_W-1:0]      mem_rdata;
   logic                   mem_ready;

   modport slave (
      input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );

endinterface

// File: rtl/dcache_array.sv
// Cache storage: valid/dirty bits are reset, tags and data are not.
// One combinational read port; one write port doing a word merge or a full line refill.
module dcache_array
   import dcache_wb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  index_t            rd_index,
   output logic              rd_valid,
   output logic              rd_dirty,
   output tag_t              rd_tag,
   output line_t             rd_line,
   input  index_t            wr_index,
   input  logic              word_we,
   input  offset_t           word_offset,
   input  logic [WORD_W-1:0] word_data,
   input  logic              line_we,
   input  tag_t              line_tag,
   input  line_t             line_data
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   tag_t                 tag_q  [NUM_LINES];
   line_t                data_q [NUM_LINES];

   assign rd_valid = valid_q[rd_index];
   assign rd_dirty = dirty_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_line  = data_q[rd_index];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we) begin
         valid_q[wr_index] <= 1'b1;
         dirty_q[wr_index] <= 1'b0;
      end else if (word_we) begin
         dirty_q[wr_index] <= 1'b1;
      end
   end

   // A refill takes priority over a word merge; nothing is written while in reset
   always_ff @(posedge clk) begin
      if (rst_n && line_we) begin
         tag_q[wr_index]  <= line_tag;
         data_q[wr_index] <= line_data;
      end else if (rst_n && word_we) begin
         data_q[wr_index][word_offset] <= word_data;
      end
   end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache: single-cycle hits,
// misses stall the core while a dirty victim is written back and the line is refilled.
module dcache_wb
   import dcache_wb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   dcache_wb_if.slave bus
);

   tag_t    req_tag;
   index_t  req_index;
   offset_t req_offset;
   logic    req;
   logic    hit;

   logic    rd_valid;
   logic    rd_dirty;
   tag_t    rd_tag;
   line_t   rd_line;

   logic    word_we;
   logic    line_we;
   index_t  wr_index;

   state_t                 state_q,     state_d;
   logic                   mem_read_q,  mem_read_d;
   logic                   mem_write_q, mem_write_d;
   logic [LINE_ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   line_t                  mem_wdata_q, mem_wdata_d;
   logic [LINE_ADDR_W-1:0] miss_line_q, miss_line_d;

   assign req_tag    = bus.proc_addr[ADDR_W-1 -: TAG_W];
   assign req_index  = bus.proc_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
   assign req_offset = bus.proc_addr[OFFSET_W-1:0];
   assign req        = bus.proc_read | bus.proc_write;
   assign hit        = rd_valid && (rd_tag == req_tag);

   assign bus.proc_stall = req && !(state_q == IDLE && hit);
   assign bus.proc_rdata = bus.proc_read ? rd_line[req_offset] : '0;
   assign bus.mem_read   = mem_read_q;
   assign bus.mem_write  = mem_write_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

   // The refill lands on the latched miss line, so it survives the core dropping its request
   assign wr_index = line_we ? miss_line_q[INDEX_W-1:0] : req_index;

   dcache_array u_array (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_index    (req_index),
      .rd_valid    (rd_valid),
      .rd_dirty    (rd_dirty),
      .rd_tag      (rd_tag),
      .rd_line     (rd_line),
      .wr_index    (wr_index),
      .word_we     (word_we),
      .word_offset (req_offset),
      .word_data   (bus.proc_wdata),
      .line_we     (line_we),
      .line_tag    (miss_line_q[LINE_ADDR_W-1 -: TAG_W]),
      .line_data   (bus.mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         miss_line_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         miss_line_q <= miss_line_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      miss_line_d = miss_line_q;
      word_we     = 1'b0;
      line_we     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  word_we = bus.proc_write;
               end else begin
                  miss_line_d = bus.proc_addr[ADDR_W-1:OFFSET_W];
                  if (rd_valid && rd_dirty) begin
                     state_d     = WRITEBACK;
                     mem_write_d = 1'b1;
                     mem_addr_d  = line_addr(rd_tag, req_index);
                     mem_wdata_d = rd_line;
                  end else begin
                     state_d    = ALLOCATE;
                     mem_read_d = 1'b1;
                     mem_addr_d = bus.proc_addr[ADDR_W-1:OFFSET_W];
                  end
               end
            end
         end

         WRITEBACK: begin
            if (bus.mem_ready) begin
               mem_write_d = 1'b0;
               if (req) begin
                  state_d    = ALLOCATE;
                  mem_read_d = 1'b1;
                  mem_addr_d = miss_line_q;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         ALLOCATE: begin
            if (bus.mem_ready) begin
               line_we    = 1'b1;
               mem_read_d = 1'b0;
               state_d    = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: a behavioural memory with fixed latency, a golden word-level
// memory for load data, and queues of expected load data and memory transactions.
module tb_dcache_wb;
   import dcache_wb_pkg::*;

   localparam int MEM_LAT = 2;
   localparam int TIMEOUT = 40;

   typedef struct {
      logic                   we;
      logic [LINE_ADDR_W-1:0] addr;
      logic [LINE_W-1:0]      data;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   both_high = 0;
   int   mem_wait = 0;
   logic inject_ready = 1'b0;

   logic [LINE_W-1:0] mem_lines [logic [LINE_ADDR_W-1:0]];
   logic [WORD_W-1:0] golden    [logic [ADDR_W-1:0]];
   txn_t              obs_q[$];
   txn_t              exp_q[$];
   logic [WORD_W-1:0] exp_rd_q[$];

   dcache_wb_if bus ();

   dcache_wb dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [WORD_W-1:0] init_word(input logic [ADDR_W-1:0] a);
      return {2'b10, a};
   endfunction

   function automatic logic [LINE_W-1:0] mem_line(input logic [LINE_ADDR_W-1:0] la);
      if (mem_lines.exists(la)) return mem_lines[la];
      return {init_word({la, 2'd3}), init_word({la, 2'd2}), init_word({la, 2'd1}), init_word({la, 2'd0})};
   endfunction

   function automatic logic [WORD_W-1:0] gold(input logic [ADDR_W-1:0] a);
      if (golden.exists(a)) return golden[a];
      return init_word(a);
   endfunction

   function automatic logic [LINE_W-1:0] gold_line(input logic [LINE_ADDR_W-1:0] la);
      return {gold({la, 2'd3}), gold({la, 2'd2}), gold({la, 2'd1}), gold({la, 2'd0})};
   endfunction

   // Memory answers each request MEM_LAT negedges after it first sees it
   always @(negedge clk) begin
      txn_t t;
      bus.mem_ready = inject_ready;
      if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) both_high++;
      if (rst_n !== 1'b1 || !(bus.mem_read === 1'b1 || bus.mem_write === 1'b1)) begin
         mem_wait = 0;
      end else if (mem_wait == MEM_LAT) begin
         mem_wait      = 0;
         bus.mem_ready = 1'b1;
         t.we   = bus.mem_write;
         t.addr = bus.mem_addr;
         t.data = bus.mem_write ? bus.mem_wdata : mem_line(bus.mem_addr);
         if (bus.mem_write) mem_lines[bus.mem_addr] = bus.mem_wdata;
         else bus.mem_rdata = mem_line(bus.mem_addr);
         obs_q.push_back(t);
      end else begin
         mem_wait++;
      end
   end

   task automatic release_bus();
      @(negedge clk);
      bus.proc_read  = 1'b0;
      bus.proc_write = 1'b0;
   endtask

   task automatic access(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [WORD_W-1:0] wdata, output logic [WORD_W-1:0] rdata,
                         output int cycles);
      @(negedge clk);
      bus.proc_read  = rd;
      bus.proc_write = wr;
      bus.proc_addr  = addr;
      bus.proc_wdata = wdata;
      #1;
      cycles = 0;
      while (bus.proc_stall === 1'b1 && cycles < TIMEOUT) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      checks++;
      if (bus.proc_stall !== 1'b0) begin
         failures++;
         $display("[TB] FAIL access_timeout addr=%h stall=%b required 0", addr, bus.proc_stall);
      end
      rdata = bus.proc_rdata;
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus.proc_read  = 1'b0;
      bus.proc_write = 1'b0;
      bus.proc_addr  = '0;
      bus.proc_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checks += 7;
      if (bus.proc_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b exp=0", bus.proc_stall); end
      if (bus.mem_read !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_read got=%b exp=0", bus.mem_read); end
      if (bus.mem_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_write got=%b exp=0", bus.mem_write); end
      if (bus.mem_addr !== '0) begin failures++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
      if (bus.mem_wdata !== '0) begin failures++; $display("[TB] FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
      if (bus.proc_rdata !== '0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", bus.proc_rdata); end
      if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_cold_read();
      logic [WORD_W-1:0] exp;
      int cycles;
      obs_q.delete();
      @(negedge clk);
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h10;
      exp_rd_q.push_back(gold(30'h10));
      #1;
      checks++;
      if (bus.proc_stall !== 1'b1) begin failures++; $display("[TB] FAIL cold_stall got=%b exp=1", bus.proc_stall); end
      @(negedge clk);
      #1;
      checks += 3;
      if (bus.mem_read !== 1'b1) begin failures++; $display("[TB] FAIL cold_mem_read got=%b exp=1", bus.mem_read); end
      if (bus.mem_write !== 1'b0) begin failures++; $display("[TB] FAIL cold_mem_write got=%b exp=0", bus.mem_write); end
      if (bus.mem_addr !== 28'h4) begin failures++; $display("[TB] FAIL cold_mem_addr got=%h exp=4", bus.mem_addr); end
      cycles = 1;
      while (bus.proc_stall === 1'b1 && cycles < TIMEOUT) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      exp = exp_rd_q.pop_front();
      checks += 4;
      if (bus.proc_stall !== 1'b0) begin failures++; $display("[TB] FAIL cold_timeout stall=%b exp=0", bus.proc_stall); end
      if (bus.proc_rdata !== exp) begin failures++; $display("[TB] FAIL cold_rdata got=%h exp=%h", bus.proc_rdata, exp); end
      if (bus.mem_read !== 1'b0) begin failures++; $display("[TB] FAIL cold_mem_read_drop got=%b exp=0", bus.mem_read); end
      if (obs_q.size() != 1) begin failures++; $display("[TB] FAIL cold_txn_count got=%0d exp=1", obs_q.size()); end
      release_bus();
   endtask

   task automatic test_back_to_back();
      logic [WORD_W-1:0] rd, exp;
      int cycles;
      for (int i = 0; i < 4; i++) begin
         exp_rd_q.push_back(gold(30'h10 + 30'(i)));
         access(1'b1, 1'b0, 30'h10 + 30'(i), '0, rd, cycles);
         exp = exp_rd_q.pop_front();
         checks += 2;
         if (rd !== exp) begin failures++; $display("[TB] FAIL b2b_rdata[%0d] got=%h exp=%h", i, rd, exp); end
         if (cycles != 0) begin failures++; $display("[TB] FAIL b2b_stall[%0d] got=%0d cycles exp=0", i, cycles); end
      end
      release_bus();
   endtask

   task automatic test_write_hit();
      logic [WORD_W-1:0] rd, exp;
      int cycles;
      obs_q.delete();
      @(negedge clk);
      inject_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      inject_ready = 1'b0;
      golden[30'h11] = 32'hCAFEF00D;
      access(1'b0, 1'b1, 30'h11, 32'hCAFEF00D, rd, cycles);
      checks++;
      if (cycles != 0) begin failures++; $display("[TB] FAIL wr_hit_stall got=%0d cycles exp=0", cycles); end
      exp_rd_q.push_back(gold(30'h11));
      access(1'b1, 1'b0, 30'h11, '0, rd, cycles);
      exp = exp_rd_q.pop_front();
      checks += 5;
      if (cycles != 0) begin failures++; $display("[TB] FAIL wr_hit_rd_stall got=%0d cycles exp=0", cycles); end
      if (rd !== exp) begin failures++; $display("[TB] FAIL wr_hit_rdata got=%h exp=%h", rd, exp); end
      if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL wr_hit_traffic got=%0d txns exp=0", obs_q.size()); end
      if (bus.mem_read !== 1'b0) begin failures++; $display("[TB] FAIL wr_hit_mem_read got=%b exp=0", bus.mem_read); end
      if (bus.mem_write !== 1'b0) begin failures++; $display("[TB] FAIL wr_hit_mem_write got=%b exp=0", bus.mem_write); end
      release_bus();
   endtask

   task automatic test_dirty_evict();
      logic [WORD_W-1:0] rd, exp;
      int cycles;
      txn_t e, o;
      obs_q.delete();
      exp_q.delete();
      both_high = 0;
      e.we = 1'b1; e.addr = 28'h004; e.data = gold_line(28'h004); exp_q.push_back(e);
      e.we = 1'b0; e.addr = 28'h024; e.data = '0;                 exp_q.push_back(e);
      exp_rd_q.push_back(gold(30'h91));
      access(1'b1, 1'b0, 30'h91, '0, rd, cycles);
      exp = exp_rd_q.pop_front();
      checks++;
      if (rd !== exp) begin failures++; $display("[TB] FAIL evict_rdata got=%h exp=%h", rd, exp); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++; $display("[TB] FAIL evict_txn_missing got=none exp=we%b@%h", e.we, e.addr);
         end else begin
            o = obs_q.pop_front();
            if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
               failures++;
               $display("[TB] FAIL evict_txn got=we%b@%h data=%h exp=we%b@%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
         end
      end
      checks += 2;
      if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL evict_extra_txn got=%0d exp=0", obs_q.size()); end
      if (both_high != 0) begin failures++; $display("[TB] FAIL evict_read_write_overlap got=%0d exp=0", both_high); end
      release_bus();
   endtask

   task automatic test_write_miss();
      logic [WORD_W-1:0] rd, exp;
      int cycles;
      txn_t e, o;
      obs_q.delete();
      exp_q.delete();
      e.we = 1'b0; e.addr = 28'h00A; e.data = '0; exp_q.push_back(e);
      golden[30'h2A] = 32'h12345678;
      access(1'b0, 1'b1, 30'h2A, 32'h12345678, rd, cycles);
      checks++;
      if (cycles != MEM_LAT + 2) begin failures++; $display("[TB] FAIL wmiss_latency got=%0d exp=%0d", cycles, MEM_LAT + 2); end
      exp_rd_q.push_back(gold(30'h2A));
      access(1'b1, 1'b0, 30'h2A, '0, rd, cycles);
      exp = exp_rd_q.pop_front();
      checks += 2;
      if (cycles != 0) begin failures++; $display("[TB] FAIL wmiss_rd_stall got=%0d exp=0", cycles); end
      if (rd !== exp) begin failures++; $display("[TB] FAIL wmiss_merge got=%h exp=%h", rd, exp); end
      e.we = 1'b1; e.addr = 28'h00A; e.data = gold_line(28'h00A); exp_q.push_back(e);
      e.we = 1'b0; e.addr = 28'h012; e.data = '0;                 exp_q.push_back(e);
      exp_rd_q.push_back(gold(30'h4A));
      access(1'b1, 1'b0, 30'h4A, '0, rd, cycles);
      exp = exp_rd_q.pop_front();
      checks++;
      if (rd !== exp) begin failures++; $display("[TB] FAIL wmiss_evict_rdata got=%h exp=%h", rd, exp); end
      e.we = 1'b0; e.addr = 28'h004; e.data = '0; exp_q.push_back(e);
      exp_rd_q.push_back(gold(30'h11));
      access(1'b1, 1'b0, 30'h11, '0, rd, cycles);
      exp = exp_rd_q.pop_front();
      checks++;
      if (rd !== exp) begin failures++; $display("[TB] FAIL clean_evict_rdata got=%h exp=%h", rd, exp); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++; $display("[TB] FAIL wmiss_txn_missing got=none exp=we%b@%h", e.we, e.addr);
         end else begin
            o = obs_q.pop_front();
            if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
               failures++;
               $display("[TB] FAIL wmiss_txn got=we%b@%h data=%h exp=we%b@%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL wmiss_extra_txn got=%0d exp=0", obs_q.size()); end
      release_bus();
   endtask

   task automatic test_reset_mid_allocate();
      logic [WORD_W-1:0] rd, exp;
      int cycles;
      txn_t o;
      obs_q.delete();
      @(negedge clk);
      bus.proc_read = 1'b1;
      bus.proc_addr = 30'h70;
      @(negedge clk);
      #1;
      checks += 2;
      if (bus.mem_read !== 1'b1) begin failures++; $display("[TB] FAIL abort_mem_read_pre got=%b exp=1", bus.mem_read); end
      if (bus.mem_addr !== 28'h01C) begin failures++; $display("[TB] FAIL abort_mem_addr got=%h exp=01c", bus.mem_addr); end
      rst_n         = 1'b0;
      bus.proc_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks += 3;
      if (bus.mem_read !== 1'b0) begin failures++; $display("[TB] FAIL abort_mem_read got=%b exp=0", bus.mem_read); end
      if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL abort_state got=%0d exp=%0d", dut.state_q, IDLE); end
      if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL abort_txn got=%0d exp=0", obs_q.size()); end
      exp_rd_q.push_back(gold(30'h70));
      access(1'b1, 1'b0, 30'h70, '0, rd, cycles);
      exp = exp_rd_q.pop_front();
      checks += 3;
      if (cycles != MEM_LAT + 2) begin failures++; $display("[TB] FAIL abort_remiss got=%0d cycles exp=%0d", cycles, MEM_LAT + 2); end
      if (rd !== exp) begin failures++; $display("[TB] FAIL abort_rdata got=%h exp=%h", rd, exp); end
      if (obs_q.size() != 1) begin
         failures++; $display("[TB] FAIL abort_refill_count got=%0d exp=1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks++;
         if (o.we !== 1'b0 || o.addr !== 28'h01C) begin
            failures++; $display("[TB] FAIL abort_refill got=we%b@%h exp=we0@01c", o.we, o.addr);
         end
      end
      release_bus();
   endtask

   initial begin
      golden[30'h10]   = 32'hDEADBEEF;
      mem_lines[28'h4] = {init_word(30'h13), init_word(30'h12), init_word(30'h11), 32'hDEADBEEF};
      test_reset();
      test_cold_read();
      test_back_to_back();
      test_write_hit();
      test_dirty_evict();
      test_write_miss();
      test_reset_mid_allocate();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=running exp=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
